adc_scan_seq: RTL and testbench

//  Parametrised SAR scan sequencer in core logic. Drives the anatop comparator mux select, the
//  DAC1 code, sample/hold and the comparator enable. Round-robins over a channel mask and

---
 rtl/adc_scan_seq.sv | 139 +++++++++++++
 tb/tb_adc_scan_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_seq.sv
// adc_scan_seq: SAR scan sequencer driving comparator mux select, DAC code and sample/hold.
// Round-robins over a channel mask; each channel is resolved by binary search or a threshold compare.
module adc_scan_seq #(
    parameter int NCH    = 18,
    parameter int DACW   = 10,
    parameter int SAMP   = 4,
    parameter int SETTLE = 3,
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            i_clk,
    input  logic            i_rstz,
    input  logic            i_scan_en,
    input  logic            i_one_shot,
    input  logic [NCH-1:0]  i_ch_mask,
    input  logic            i_cmp_mode,
    input  logic [DACW-1:0] i_thr_code,
    input  logic            i_comp_o,
    output logic [NCH-1:0]  o_dac_sel,
    output logic [DACW-1:0] o_dac_code,
    output logic            o_dac_en,
    output logic            o_sh_rst,
    output logic            o_sh_hold,
    output logic            o_busy,
    output logic            o_res_vld,
    output logic [CW-1:0]   o_res_ch,
    output logic [DACW-1:0] o_res_dat,
    output logic            o_res_above
);
    localparam int MAXC = (SAMP > SETTLE) ? SAMP : SETTLE;
    localparam int NW   = $clog2(MAXC + 1);
    localparam int BW   = $clog2(DACW + 1);

    typedef enum logic [2:0] {IDLE, SEL, HOLD, CONV, DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [CW-1:0]   r_ptr, w_lo, w_above, w_next, r_res_ch;
    logic [NW-1:0]   r_cnt;
    logic [BW-1:0]   r_bit;
    logic [DACW-1:0] r_code, r_thr, r_res_dat, w_trial, w_code_new;
    logic            r_cmp, r_cont, r_sync1, r_sync2, r_res_above;
    logic            w_more, w_samp_end, w_trial_end, w_conv_end, w_abort, w_start, w_pick;

    assign w_samp_end  = r_cnt == NW'(SAMP - 1);
    assign w_trial_end = r_cnt == NW'(SETTLE - 1);
    assign w_conv_end  = w_trial_end && (r_cmp || r_bit == '0);
    assign w_abort     = r_cont && !i_scan_en && r_state != IDLE;
    assign w_start     = (i_scan_en || i_one_shot) && |i_ch_mask;
    assign w_trial     = DACW'(1) << r_bit;
    assign w_code_new  = r_sync2 ? (r_code | w_trial) : r_code;
    assign w_next      = w_more ? w_above : w_lo;
    assign w_pick      = w_state_nxt == SEL && r_state != SEL;

    // lowest enabled channel overall, and lowest enabled channel above the pointer
    always_comb begin
        w_lo    = '0;
        w_above = '0;
        w_more  = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (i_ch_mask[k]) w_lo = CW'(k);
            if (i_ch_mask[k] && k > int'(r_ptr)) begin
                w_above = CW'(k);
                w_more  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstz) begin
        if (!i_rstz) {r_sync2, r_sync1} <= '0;
        else         {r_sync2, r_sync1} <= {r_sync1, i_comp_o};
    end

    always_ff @(posedge i_clk or negedge i_rstz) begin
        if (!i_rstz) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_start ? SEL : IDLE;
            SEL:     w_state_nxt = w_samp_end ? HOLD : SEL;
            HOLD:    w_state_nxt = CONV;
            CONV:    w_state_nxt = w_conv_end ? DONE : CONV;
            DONE:    w_state_nxt = (|i_ch_mask && (i_scan_en || (!r_cont && w_more))) ? SEL : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) w_state_nxt = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rstz) begin
        if (!i_rstz) begin
            r_ptr       <= CW'(NCH - 1);
            r_cnt       <= '0;
            r_bit       <= '0;
            r_code      <= '0;
            r_thr       <= '0;
            r_cmp       <= 1'b0;
            r_cont      <= 1'b0;
            r_res_ch    <= '0;
            r_res_dat   <= '0;
            r_res_above <= 1'b0;
        end else begin
            r_cnt <= (w_state_nxt == r_state && (r_state == SEL || (r_state == CONV && !w_trial_end)))
                     ? r_cnt + 1'b1 : '0;
            // a one-shot pass out of IDLE always starts at the lowest enabled channel
            if (w_pick) begin
                r_ptr  <= (r_state == IDLE && !i_scan_en) ? w_lo : w_next;
                r_cont <= i_scan_en;
                r_cmp  <= i_cmp_mode;
                r_thr  <= i_thr_code;
                r_code <= '0;
                r_bit  <= BW'(DACW - 1);
            end
            if (r_state == CONV && w_trial_end) begin
                r_code <= w_code_new;
                r_bit  <= (r_bit == '0) ? r_bit : r_bit - 1'b1;
            end
            if (r_state == CONV && w_state_nxt == DONE) begin
                r_res_ch    <= r_ptr;
                r_res_dat   <= r_cmp ? r_thr : w_code_new;
                r_res_above <= r_cmp ? r_sync2 : |w_code_new;
            end
        end
    end

    always_comb begin
        o_dac_sel  = (r_state inside {SEL, HOLD, CONV}) ? NCH'(1) << r_ptr : '0;
        o_dac_en   = r_state inside {SEL, HOLD, CONV};
        o_dac_code = (r_state == CONV) ? (r_cmp ? r_thr : (r_code | w_trial)) : '0;
        o_sh_rst   = r_state == SEL;
        o_sh_hold  = r_state inside {HOLD, CONV};
        o_busy     = r_state != IDLE;
        o_res_vld  = r_state == DONE;
    end

    assign o_res_ch    = r_res_ch;
    assign o_res_dat   = r_res_dat;
    assign o_res_above = r_res_above;
endmodule

// File: tb/tb_adc_scan_seq.sv
// tb_adc_scan_seq: scoreboard bench; expected results queued by stimulus, checked by a monitor.
// Comparator modelled as comp_o = v[ch] >= dac_code.
module tb_adc_scan_seq;
    localparam int NCH = 4, DACW = 10, SAMP = 4, SETTLE = 3;
    localparam int LAT_SAR = SAMP + 1 + DACW * SETTLE;
    localparam int LAT_CMP = SAMP + 1 + SETTLE;
    localparam int CODE_MAX = (1 << DACW) - 1;

    logic            clk = 1'b0, rstz = 1'b0, scan_en = 1'b0, one_shot = 1'b0, cmp_mode = 1'b0;
    logic [NCH-1:0]  ch_mask = '0;
    logic [DACW-1:0] thr_code = '0;
    logic            comp_o;
    logic [NCH-1:0]  dac_sel;
    logic [DACW-1:0] dac_code, res_dat;
    logic            dac_en, sh_rst, sh_hold, busy, res_vld, res_above;
    logic [1:0]      res_ch;

    typedef struct {int ch; int dat; int above; int lat; int gap;} exp_t;
    exp_t q[$];
    int v[NCH];
    int cyc = 0, tests = 0, fails = 0, ptr = NCH - 1;

    adc_scan_seq #(.NCH(NCH), .DACW(DACW), .SAMP(SAMP), .SETTLE(SETTLE)) dut (
        .i_clk(clk), .i_rstz(rstz), .i_scan_en(scan_en), .i_one_shot(one_shot),
        .i_ch_mask(ch_mask), .i_cmp_mode(cmp_mode), .i_thr_code(thr_code), .i_comp_o(comp_o),
        .o_dac_sel(dac_sel), .o_dac_code(dac_code), .o_dac_en(dac_en), .o_sh_rst(sh_rst),
        .o_sh_hold(sh_hold), .o_busy(busy), .o_res_vld(res_vld), .o_res_ch(res_ch),
        .o_res_dat(res_dat), .o_res_above(res_above)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        comp_o = 1'b0;
        for (int k = 0; k < NCH; k++)
            if (dac_sel[k]) comp_o = v[k] >= int'(dac_code);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nxt(input int p, input logic [NCH-1:0] m);
        for (int i = 1; i <= NCH; i++)
            if (m[(p + i) % NCH]) return (p + i) % NCH;
        return p;
    endfunction

    // binary search against v >= code settles on the largest code not above v
    function automatic int sar_ref(input int x);
        return x < 0 ? 0 : (x > CODE_MAX ? CODE_MAX : x);
    endfunction

    task automatic push_exp(input int c, input bit cmp, input int thr, input bit first);
        exp_t e;
        int lat = cmp ? LAT_CMP : LAT_SAR;
        e.ch    = c;
        e.dat   = cmp ? thr : sar_ref(v[c]);
        e.above = cmp ? int'(v[c] >= thr) : int'(sar_ref(v[c]) != 0);
        e.lat   = lat;
        e.gap   = first ? 0 : lat + 1;
        q.push_back(e);
    endtask

    task automatic wait_vld(input int n, input bit stop);
        int seen = 0, t = 0;
        while (seen < n && t < n * (LAT_SAR + 2) + 20) begin
            @(negedge clk);
            t++;
            if (res_vld) begin
                seen++;
                if (seen == n && stop) scan_en = 1'b0;
            end
        end
        chk("res_vld_count", seen, n);
    endtask

    task automatic run_cont(input logic [NCH-1:0] m, input int n, input bit cmp, input int thr);
        ch_mask  = m;
        cmp_mode = cmp;
        thr_code = DACW'(thr);
        for (int i = 0; i < n; i++) begin
            ptr = nxt(ptr, m);
            push_exp(ptr, cmp, thr, i == 0);
        end
        scan_en = 1'b1;
        wait_vld(n, 1'b1);
        repeat (2) @(negedge clk);
        chk("busy_after_stop", busy, 0);
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic pulse_os();
        @(negedge clk) one_shot = 1'b1;
        @(negedge clk) one_shot = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_dac_sel"}, dac_sel, 0);
        chk({tag, "_dac_code"}, dac_code, 0);
        chk({tag, "_dac_en"}, dac_en, 0);
        chk({tag, "_sh_rst"}, sh_rst, 0);
        chk({tag, "_sh_hold"}, sh_hold, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_res_vld"}, res_vld, 0);
    endtask

    initial begin : monitor
        int rise_cyc = 0, last_vld = 0;
        logic [NCH-1:0] prev_sel = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rstz) begin
                prev_sel = '0;
            end else begin
                if (dac_sel != 0 && prev_sel == 0) rise_cyc = cyc;
                if (dac_sel != 0) begin
                    chk("sh_rst_phase", sh_rst, int'(cyc - rise_cyc < SAMP));
                    chk("sh_hold_phase", sh_hold, int'(cyc - rise_cyc >= SAMP));
                    chk("dac_en_active", dac_en, 1);
                end
                if (res_vld) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_res_vld: got ch %0d dat %0d, expected none", res_ch, res_dat);
                    end else begin
                        e = q.pop_front();
                        chk("res_ch", res_ch, e.ch);
                        chk("res_dat", res_dat, e.dat);
                        chk("res_above", res_above, e.above);
                        chk("latency", cyc - rise_cyc, e.lat);
                        chk("done_sh_hold", sh_hold, 0);
                        if (e.gap != 0) chk("period", cyc - last_vld, e.gap);
                    end
                    last_vld = cyc;
                end
                prev_sel = dac_sel;
            end
        end
    end

    initial begin
        v = '{300, 900, 700, 0};
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        chk("reset_res_ch", res_ch, 0);
        chk("reset_res_dat", res_dat, 0);
        chk("reset_res_above", res_above, 0);
        rstz = 1'b1;
        scan_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_empty_mask", busy, 0);
        scan_en = 1'b0;

        run_cont(4'b0101, 4, 1'b0, 0);

        v[0] = 0;
        v[1] = CODE_MAX;
        run_cont(4'b0011, 2, 1'b0, 0);

        v[3] = 600;
        ch_mask = 4'b1000;
        cmp_mode = 1'b1;
        thr_code = 10'd512;
        push_exp(3, 1'b1, 512, 1'b1);
        pulse_os();
        wait_vld(1, 1'b0);
        repeat (2) @(negedge clk);
        chk("cmp_oneshot_busy", busy, 0);
        ptr = 3;
        cmp_mode = 1'b0;

        for (int c = 1; c < NCH; c++) v[c] = int'($urandom_range(0, CODE_MAX));
        ch_mask = 4'b1110;
        for (int c = 1; c < NCH; c++) push_exp(c, 1'b0, 0, c == 1);
        pulse_os();
        repeat (10) @(negedge clk);
        pulse_os();
        wait_vld(3, 1'b0);
        repeat (2) @(negedge clk);
        chk("oneshot_busy", busy, 0);
        repeat (60) @(negedge clk);
        chk("oneshot_no_extra", q.size(), 0);
        ptr = 3;

        v[0] = 123;
        v[2] = 1000;
        ch_mask = 4'b0101;
        ptr = nxt(ptr, ch_mask);
        push_exp(ptr, 1'b0, 0, 1'b1);
        scan_en = 1'b1;
        wait_vld(1, 1'b0);
        repeat (15) @(negedge clk);
        scan_en = 1'b0;
        @(negedge clk);
        chk_quiet("abort");
        ptr = nxt(ptr, ch_mask);
        repeat (60) @(negedge clk);
        chk("abort_no_res", q.size(), 0);
        run_cont(4'b0101, 2, 1'b0, 0);

        for (int r = 0; r < 6; r++) begin
            logic [NCH-1:0] m = NCH'($urandom_range(1, (1 << NCH) - 1));
            for (int c = 0; c < NCH; c++) begin
                int s = int'($urandom_range(0, 3));
                v[c] = s == 0 ? 0 : (s == 1 ? CODE_MAX : int'($urandom_range(0, CODE_MAX)));
            end
            run_cont(m, int'($urandom_range(2, 4)), $urandom_range(0, 2) == 0, int'($urandom_range(0, CODE_MAX)));
        end

        ch_mask = 4'b0110;
        cmp_mode = 1'b0;
        scan_en = 1'b1;
        begin
            int t = 0;
            while (dac_sel == 0 && t < 10) begin
                @(negedge clk);
                t++;
            end
            chk("sel_rise_before_reset", int'(dac_sel != 0), 1);
        end
        repeat (12) @(negedge clk);
        #2 rstz = 1'b0;
        #1;
        chk_quiet("async_reset");
        scan_en = 1'b0;
        @(negedge clk) rstz = 1'b1;
        ptr = NCH - 1;
        run_cont(4'b0110, 2, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
